// File: rtl/w_engine_pkg.sv
// Shared types and default parameters for the W residue chunk engine.
// Holds the iteration FSM state type and the default geometry constants.
package w_engine_pkg;

  localparam int unsigned DefChunkW = 4;
  localparam int unsigned DefNChunk = 2;
  localparam int unsigned DefUpperW = 6;
  localparam int unsigned DefAddrW  = 7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StUpper = 2'd2
  } w_state_e;

endpackage

// File: rtl/w_chunk_ram.sv
// Residue chunk storage: one write port, one synchronous read-first read port.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears read register only)
//   we_i, waddr_i     write enable / address
//   wdata_i           write data
//   re_i, raddr_i     read enable / address; rdata_o updates one cycle later
//   rdata_o           registered read data (pre-write word on address collision)
module w_chunk_ram #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read sees the old word when writing the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/w_residue_chunk_engine.sv
// Processes one residue iteration: streams NCHUNK lower chunks from the adder into
// the chunk RAM (optionally shifted left by one bit across chunk boundaries), then
// folds the final carry and shift-out bits into the upper residue rails.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start_i, shift_en_i                begin iteration; 1 = shift left one bit
//   chunk_valid_i / chunk_ready_o      chunk handshake
//   chunk_plus_i, chunk_minus_i        adder result rails for the current chunk
//   cout_i / cin_o                     adder carry {plus,minus} in / registered carry out
//   upper_plus_i, upper_minus_i        upper adder rails
//   res_plus_o, res_minus_o, res_valid_o  stored chunk at the current index
//   upper_shifted_plus_o/_minus_o      updated upper residue
//   iter_done_o, iter_count_o          completion pulse, completed iteration count
module w_residue_chunk_engine
  import w_engine_pkg::*;
#(
  parameter int unsigned CHUNK_W = DefChunkW,
  parameter int unsigned NCHUNK  = DefNChunk,
  parameter int unsigned UPPER_W = DefUpperW,
  parameter int unsigned ADDR_W  = DefAddrW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               shift_en_i,
  input  logic               chunk_valid_i,
  output logic               chunk_ready_o,
  input  logic [CHUNK_W-1:0] chunk_plus_i,
  input  logic [CHUNK_W-1:0] chunk_minus_i,
  input  logic [1:0]         cout_i,
  output logic [1:0]         cin_o,
  input  logic [UPPER_W-1:0] upper_plus_i,
  input  logic [UPPER_W-1:0] upper_minus_i,
  output logic [CHUNK_W-1:0] res_plus_o,
  output logic [CHUNK_W-1:0] res_minus_o,
  output logic               res_valid_o,
  output logic [UPPER_W-1:0] upper_shifted_plus_o,
  output logic [UPPER_W-1:0] upper_shifted_minus_o,
  output logic               iter_done_o,
  output logic [ADDR_W-1:0]  iter_count_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NCHUNK - 1);

  w_state_e           state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [1:0]         cin_q, cin_d;
  logic               sin_p_q, sin_p_d, sin_m_q, sin_m_d;
  logic               shift_q, shift_d;
  logic [UPPER_W-1:0] up_p_q, up_p_d, up_m_q, up_m_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               res_valid_q;
  logic               accept;
  logic [CHUNK_W-1:0] wr_p, wr_m;
  logic [UPPER_W-2:0] u_p, u_m;

  assign accept = (state_q == StRun) && chunk_valid_i;

  // In shift mode the top bit of each chunk carries into the bottom of the next.
  assign wr_p = shift_q ? {chunk_plus_i[CHUNK_W-2:0], sin_p_q}  : chunk_plus_i;
  assign wr_m = shift_q ? {chunk_minus_i[CHUNK_W-2:0], sin_m_q} : chunk_minus_i;

  assign u_p = upper_plus_i[UPPER_W-2:0]  + (UPPER_W-1)'(cin_q[1]);
  assign u_m = upper_minus_i[UPPER_W-2:0] + (UPPER_W-1)'(cin_q[0]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    sin_p_d = sin_p_q;
    sin_m_d = sin_m_q;
    shift_d = shift_q;
    up_p_d  = up_p_q;
    up_m_d  = up_m_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = '0;
          cin_d   = '0;
          sin_p_d = 1'b0;
          sin_m_d = 1'b0;
          shift_d = shift_en_i;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          cin_d = cout_i;
          if (shift_q) begin
            sin_p_d = chunk_plus_i[CHUNK_W-1];
            sin_m_d = chunk_minus_i[CHUNK_W-1];
          end
          if (idx_q == LastIdx) begin
            state_d = StUpper;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StUpper: begin
        up_p_d  = shift_q ? {u_p, sin_p_q} : {1'b0, u_p};
        up_m_d  = shift_q ? {u_m, sin_m_q} : {1'b0, u_m};
        cnt_d   = cnt_q + 1'b1;
        cin_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cin_q       <= '0;
      sin_p_q     <= 1'b0;
      sin_m_q     <= 1'b0;
      shift_q     <= 1'b0;
      up_p_q      <= '0;
      up_m_q      <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cin_q       <= cin_d;
      sin_p_q     <= sin_p_d;
      sin_m_q     <= sin_m_d;
      shift_q     <= shift_d;
      up_p_q      <= up_p_d;
      up_m_q      <= up_m_d;
      cnt_q       <= cnt_d;
      res_valid_q <= (state_q == StRun);
    end
  end

  w_chunk_ram #(
    .DataW(2 * CHUNK_W),
    .AddrW(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (accept),
    .waddr_i(idx_q),
    .wdata_i({wr_p, wr_m}),
    .re_i   (state_q == StRun),
    .raddr_i(idx_q),
    .rdata_o({res_plus_o, res_minus_o})
  );

  assign chunk_ready_o         = (state_q == StRun);
  assign cin_o                 = cin_q;
  assign res_valid_o           = res_valid_q;
  assign upper_shifted_plus_o  = up_p_q;
  assign upper_shifted_minus_o = up_m_q;
  assign iter_done_o           = (state_q == StUpper);
  assign iter_count_o          = cnt_q;

endmodule

// File: doc/w_residue_chunk_engine.md
W_RESIDUE_CHUNK_ENGINE -- requirements
Module: w_residue_chunk_engine

Interface
REQ-001 SHALL have parameter CHUNK_W, default 4, lower residue chunk width per rail (>=2).
REQ-002 SHALL have parameter NCHUNK, default 2, chunks per residue word (>=1).
REQ-003 SHALL have parameter UPPER_W, default 6, upper residue width per rail (>=2).
REQ-004 SHALL have parameter ADDR_W, default 7, residue RAM address width; RAM depth 2**ADDR_W, NCHUNK <= 2**ADDR_W.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  begin one iteration; shift_en  in  1  1 = shift left by one bit, 0 = store unshifted (init pass).
REQ-007 SHALL have ports: chunk_valid  in  1; chunk_ready  out  1; chunk_plus, chunk_minus  in  CHUNK_W  adder result rails.
REQ-008 SHALL have ports: cout  in  2  adder carry {plus,minus}; cin  out  2  registered carry fed back to adder.
REQ-009 SHALL have ports: upper_plus_in, upper_minus_in  in  UPPER_W  upper adder rails.
REQ-010 SHALL have ports: res_plus, res_minus  out  CHUNK_W  stored chunk read for current index; res_valid  out  1.
REQ-011 SHALL have ports: upper_shifted_plus, upper_shifted_minus  out  UPPER_W; iter_done  out  1  one-cycle pulse; iter_count  out  ADDR_W  completed iterations.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> UPPER -> IDLE.
REQ-013 IDLE: start=1 SHALL clear chunk index, cin, shift-in bits; latch shift_en for the whole iteration; enter RUN next cycle. chunk_valid ignored in IDLE.
REQ-014 RUN: chunk_ready SHALL be 1; chunk_ready SHALL be 0 in IDLE and UPPER.
REQ-015 RUN: read address SHALL equal chunk index; res_plus/res_minus SHALL show the pre-write word one cycle after the index is presented (read-first RAM); res_valid SHALL be 1 in the cycle data is valid.
REQ-016 On accept (chunk_valid & chunk_ready) with shift_en=1, SHALL write {chunk_plus[CHUNK_W-2:0], sin_p} and {chunk_minus[CHUNK_W-2:0], sin_m} at chunk index, then load sin_p<=chunk_plus[CHUNK_W-1], sin_m<=chunk_minus[CHUNK_W-1].
REQ-017 On accept with shift_en=0, SHALL write chunk_plus/chunk_minus unmodified; shift-in bits stay 0.
REQ-018 On accept, cin SHALL load cout; cin SHALL hold otherwise and be 0 outside RUN/UPPER.
REQ-019 On accept of chunk NCHUNK-1, SHALL enter UPPER; else increment index. No write without accept.
REQ-020 UPPER (one cycle): u = upper_X_in[UPPER_W-2:0] + cin[X] modulo 2**(UPPER_W-1); upper_shifted_X SHALL load {u, sin_X} if shift_en else {0,u}; upper_shifted outputs otherwise hold.
REQ-021 UPPER: iter_done SHALL pulse 1 cycle; iter_count SHALL increment, wrapping at 2**ADDR_W; FSM returns to IDLE.
REQ-022 start outside IDLE SHALL be ignored; start in the cycle after iter_done SHALL be accepted.
REQ-023 NCHUNK=1: SHALL enter UPPER after the single accept.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, index 0, cin 0, shift-in 0, chunk_ready 0, res_valid 0, iter_done 0, iter_count 0, upper_shifted_* 0, RAM write-enable 0; RAM contents SHALL be undefined.
REQ-025 Reset asserted mid-RUN SHALL abort the iteration with no further writes; the first start after release SHALL begin a fresh iteration.

Structure
REQ-026 Package w_engine_pkg SHALL hold the FSM state type and default parameter constants.
REQ-027 Storage SHALL be sub-module w_chunk_ram: one write port, one synchronous read-first read port, data width 2*CHUNK_W, depth 2**ADDR_W.

Verification (CHUNK_W=4, NCHUNK=2, UPPER_W=6)
REQ-028 Reset mid-RUN after one accept -> all outputs 0 in the same cycle, next start restarts at index 0.
REQ-029 shift_en=1; plus chunks 1001, 0011; minus 0; cout 01 then 10; upper_plus_in=000101 -> RAM[0]=0010, RAM[1]=0111, upper_shifted_plus=001100, iter_done pulse, iter_count=1.
REQ-030 shift_en=0; chunks 1010, 0101 -> RAM[0]=1010, RAM[1]=0101; upper_shifted_plus = zero-extended upper_plus_in[4:0]+cin[1].
REQ-031 chunk_valid toggling 1,0,0,1 in RUN -> exactly two writes, index advances only on accept, cin changes only on accept.
REQ-032 Second iteration -> res_plus on index 0 shows 0010 written in iteration 1 (read-first); start asserted during RUN ignored.
REQ-033 upper_plus_in=011111, cin[1]=1 -> u wraps to 00000; upper_shifted_plus={00000,sin_p}.
